// File: rtl/vc_arbiter_router.sv
// Arbiter/router moving words from VC0/VC1 FIFOs into D0/D1 FIFOs.
// VC0 has priority, bounded by a burst limit; a one-entry hold register absorbs back-pressure.
module vc_arbiter_router #(
  parameter int DATA_SIZE = 6,
  parameter int DEST_BIT  = 5,
  parameter int VC0_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty_vc0,
  input  logic                 fifo_empty_vc1,
  input  logic [DATA_SIZE-1:0] data_vc0,
  input  logic [DATA_SIZE-1:0] data_vc1,
  input  logic                 fifo_pause_d0,
  input  logic                 fifo_pause_d1,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1,
  output logic                 arb_idle,
  output logic [1:0]           dbg_state
);
  localparam int CW = $clog2(VC0_BURST) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  src_q, src_d;
  logic [DATA_SIZE-1:0]  hold_data_q, hold_data_d;
  logic                  hold_dest_q, hold_dest_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d;
  logic                  push_d0_q, push_d0_d, push_d1_q, push_d1_d;
  logic [DATA_SIZE-1:0]  data_d0_q, data_d0_d, data_d1_q, data_d1_d;

  logic                  vc0_ok, vc1_ok;
  logic [DATA_SIZE-1:0]  fetch_data;
  logic                  fetch_dest, fetch_pause, hold_pause;
  logic                  allow, do_push, wr_dest;
  logic [DATA_SIZE-1:0]  wr_data;
  logic                  pop0_c, pop1_c;

  // VC0 wins unless VC1 is waiting and VC0 has used up its burst.
  assign vc0_ok = !fifo_empty_vc0 && !(!fifo_empty_vc1 && burst_cnt_q == CW'(VC0_BURST));
  assign vc1_ok = !vc0_ok && !fifo_empty_vc1;

  assign fetch_data  = src_q ? data_vc1 : data_vc0;
  assign fetch_dest  = fetch_data[DEST_BIT];
  assign fetch_pause = fetch_dest ? fifo_pause_d1 : fifo_pause_d0;
  assign hold_pause  = hold_dest_q ? fifo_pause_d1 : fifo_pause_d0;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    hold_data_d = hold_data_q;
    hold_dest_d = hold_dest_q;
    burst_cnt_d = burst_cnt_q;
    push_d0_d   = 1'b0;
    push_d1_d   = 1'b0;
    data_d0_d   = data_d0_q;
    data_d1_d   = data_d1_q;
    allow       = 1'b0;
    do_push     = 1'b0;
    wr_dest     = 1'b0;
    wr_data     = '0;

    case (state_q)
      IDLE: allow = 1'b1;
      FETCH: begin
        if (!fetch_pause) begin
          do_push = 1'b1;
          wr_data = fetch_data;
          wr_dest = fetch_dest;
          allow   = 1'b1;
        end else begin
          hold_data_d = fetch_data;
          hold_dest_d = fetch_dest;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (!hold_pause) begin
          do_push = 1'b1;
          wr_data = hold_data_q;
          wr_dest = hold_dest_q;
          allow   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_push) begin
      if (wr_dest) begin
        push_d1_d = 1'b1;
        data_d1_d = wr_data;
      end else begin
        push_d0_d = 1'b1;
        data_d0_d = wr_data;
      end
    end

    pop0_c = allow && vc0_ok;
    pop1_c = allow && vc1_ok;

    if (allow) begin
      if (pop0_c || pop1_c) begin
        state_d = FETCH;
        src_d   = pop1_c;
      end else begin
        state_d = IDLE;
      end
    end

    if (pop1_c || fifo_empty_vc1) begin
      burst_cnt_d = '0;
    end else if (pop0_c && burst_cnt_q != CW'(VC0_BURST)) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= 1'b0;
      hold_data_q <= '0;
      hold_dest_q <= 1'b0;
      burst_cnt_q <= '0;
      push_d0_q   <= 1'b0;
      push_d1_q   <= 1'b0;
      data_d0_q   <= '0;
      data_d1_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      hold_data_q <= hold_data_d;
      hold_dest_q <= hold_dest_d;
      burst_cnt_q <= burst_cnt_d;
      push_d0_q   <= push_d0_d;
      push_d1_q   <= push_d1_d;
      data_d0_q   <= data_d0_d;
      data_d1_q   <= data_d1_d;
    end
  end

  // Pops are combinational, so they are masked directly while reset is held.
  assign pop_vc0   = pop0_c && !reset;
  assign pop_vc1   = pop1_c && !reset;
  assign push_d0   = push_d0_q;
  assign push_d1   = push_d1_q;
  assign data_d0   = data_d0_q;
  assign data_d1   = data_d1_q;
  assign arb_idle  = !reset && state_q == IDLE && fifo_empty_vc0 && fifo_empty_vc1;
  assign dbg_state = state_q;
endmodule
